ascon_block_packer: RTL and testbench

//  Upstream feeder for the ASCON encryption top level. Accepts plaintext one byte
//  at a time and packs the bytes into 64-bit rate blocks. Applies ASCON 10* padding
//  and presents each block with a valid/ready handshake. The top level consumes the

---
 rtl/ascon_pack.sv | 9 +
 rtl/ascon_block_packer.sv | 181 ++++++++++++++++++
 tb/tb_ascon_block_packer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// Shared constants and state encoding for the ASCON plaintext block packer.
package ascon_pack;

  localparam logic [7:0]  PAD_BYTE   = 8'h80;
  localparam int unsigned RATE_BYTES = 8;

  typedef enum logic [1:0] {IDLE, FILL, PAD, HOLD} state_t;

endpackage

// File: rtl/ascon_block_packer.sv
// Packs a plaintext byte stream into 64-bit ASCON rate blocks with 10* padding,
// presented to the encryption top level over a valid/ready handshake.
module ascon_block_packer
  import ascon_pack::*;
#(
  parameter int unsigned MAX_BLOCKS = 4
) (
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  output logic [63:0] block_o,
  output logic        block_valid_o,
  output logic        block_last_o,
  input  logic        block_ready_i,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(MAX_BLOCKS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BLOCKS);
  localparam logic [63:0] PadBlock = {PAD_BYTE, 56'h0};

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pad_owed_q, pad_owed_d;
  logic [63:0]     block_q, block_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;

  logic            produce;
  logic [63:0]     prod_block;
  logic            prod_last;
  logic            prod_pad;

  // Writes data into lane idx; on a short final byte, the pad byte follows and
  // every later lane is zeroed.
  function automatic logic [63:0] insert_byte(input logic [63:0] blk, input logic [2:0] idx,
                                              input logic [7:0] data, input logic last);
    logic [63:0] res;
    res = blk;
    for (int k = 0; k < int'(RATE_BYTES); k++) begin
      if (k == int'(idx)) begin
        res[63-8*k -: 8] = data;
      end else if (last && (k == int'(idx) + 1)) begin
        res[63-8*k -: 8] = PAD_BYTE;
      end else if (last && (k > int'(idx))) begin
        res[63-8*k -: 8] = 8'h00;
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pad_owed_d = pad_owed_q;
    block_d    = block_q;
    valid_d    = valid_q;
    last_d     = last_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    produce    = 1'b0;
    prod_block = '0;
    prod_last  = 1'b0;
    prod_pad   = 1'b0;

    if (start_i) begin
      state_d    = FILL;
      idx_d      = '0;
      cnt_d      = '0;
      pad_owed_d = 1'b0;
      block_d    = '0;
      valid_d    = 1'b0;
      last_d     = 1'b0;
      ovf_d      = 1'b0;
      busy_d     = 1'b1;
    end else begin
      unique case (state_q)
        FILL: begin
          if (flush_i && (idx_q == 3'd0) && (cnt_q == '0)) begin
            produce    = 1'b1;
            prod_block = PadBlock;
            prod_last  = 1'b1;
          end else if (byte_valid_i && !ovf_q) begin
            if (byte_last_i || (idx_q == 3'd7)) begin
              produce    = 1'b1;
              prod_block = insert_byte(block_q, idx_q, byte_i, byte_last_i);
              prod_last  = byte_last_i && (idx_q != 3'd7);
              prod_pad   = byte_last_i && (idx_q == 3'd7);
            end else begin
              block_d = insert_byte(block_q, idx_q, byte_i, 1'b0);
              idx_d   = idx_q + 3'd1;
            end
          end
        end
        HOLD: begin
          if (block_ready_i) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CntW'(1);
            if (last_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else if (pad_owed_q) begin
              state_d    = PAD;
              pad_owed_d = 1'b0;
            end else begin
              state_d = FILL;
              block_d = '0;
            end
          end
        end
        PAD: begin
          produce    = 1'b1;
          prod_block = PadBlock;
          prod_last  = 1'b1;
        end
        default: ;
      endcase

      // A block with no room left in the core's counter is dropped, not emitted.
      if (produce) begin
        idx_d = '0;
        if (cnt_q == CntMax) begin
          ovf_d      = 1'b1;
          state_d    = IDLE;
          busy_d     = 1'b0;
          valid_d    = 1'b0;
          last_d     = 1'b0;
          pad_owed_d = 1'b0;
        end else begin
          block_d    = prod_block;
          valid_d    = 1'b1;
          last_d     = prod_last;
          pad_owed_d = prod_pad;
          state_d    = HOLD;
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pad_owed_q <= 1'b0;
      block_q    <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pad_owed_q <= pad_owed_d;
      block_q    <= block_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
    end
  end

  assign byte_ready_o  = (state_q == FILL) && !ovf_q;
  assign block_o       = block_q;
  assign block_valid_o = valid_q;
  assign block_last_o  = last_q;
  assign overflow_o    = ovf_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_ascon_block_packer.sv
// Scoreboard bench for ascon_block_packer: a padded-message reference model feeds an
// expected-block queue that an independent output monitor drains.
module tb_ascon_block_packer;

  localparam int MaxBlocks = 4;

  logic        clk = 1'b0;
  logic        resetb;
  logic        start;
  logic        flush;
  logic [7:0]  data_byte;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic [63:0] block;
  logic        block_valid;
  logic        block_last;
  logic        block_ready = 1'b0;
  logic        overflow;
  logic        busy;

  typedef struct packed {
    logic [63:0] blk;
    logic        last;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] msg[$];
  logic       stall = 1'b0;
  int         checks = 0;
  int         errors = 0;

  ascon_block_packer #(.MAX_BLOCKS(MaxBlocks)) dut (
    .clock_i      (clk),
    .resetb_i     (resetb),
    .start_i      (start),
    .flush_i      (flush),
    .byte_i       (data_byte),
    .byte_valid_i (byte_valid),
    .byte_last_i  (byte_last),
    .byte_ready_o (byte_ready),
    .block_o      (block),
    .block_valid_o(block_valid),
    .block_last_o (block_last),
    .block_ready_i(block_ready),
    .overflow_o   (overflow),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Consumer back-pressure
  always begin
    @(posedge clk);
    #1;
    block_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: a transfer happens at the next rising edge when valid & ready hold now.
  always @(negedge clk) begin
    if (resetb && block_valid && block_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block actual=%h required=none", block);
      end else begin
        mon_e = exp_q.pop_front();
        check("block_data", block, mon_e.blk);
        check("block_last", 64'(block_last), 64'(mon_e.last));
      end
    end
  end

  // Reference: append 0x80, zero-fill to a whole number of 8-byte blocks, keep at most MaxBlocks.
  task automatic push_expected(output logic exp_ovf);
    logic [7:0]  p[$];
    logic [63:0] blk;
    int          nblk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 8 != 0) p.push_back(8'h00);
    nblk = p.size() / 8;
    for (int i = 0; i < nblk && i < MaxBlocks; i++) begin
      blk = '0;
      for (int j = 0; j < 8; j++) blk = {blk[55:0], p[8*i+j]};
      exp_q.push_back('{blk: blk, last: (i == nblk - 1)});
    end
    exp_ovf = (nblk > MaxBlocks);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    repeat ($urandom_range(0, 2)) tick();
    byte_valid = 1'b1;
    data_byte  = b;
    byte_last  = last;
    n = 0;
    while (!byte_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout actual=0 required=1");
    end
    tick();
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic begin_msg(output logic exp_ovf);
    push_expected(exp_ovf);
    pulse_start();
    if (msg.size() == 0) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end else begin
      foreach (msg[i]) send_byte(msg[i], (i == msg.size() - 1));
    end
  endtask

  task automatic end_msg(input logic exp_ovf);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check("busy_drop", 64'(busy), 64'd0);
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick();
  endtask

  task automatic run_msg;
    logic ovf;
    begin_msg(ovf);
    end_msg(ovf);
  endtask

  initial begin
    logic        ovf;
    logic [63:0] snap_blk;
    logic        snap_last;
    int          n;

    resetb     = 1'b0;
    start      = 1'b0;
    flush      = 1'b0;
    data_byte  = 8'h00;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    repeat (3) tick();
    check("rst_block", block, 64'd0);
    check("rst_valid", 64'(block_valid), 64'd0);
    check("rst_last", 64'(block_last), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    resetb = 1'b1;
    tick();

    // Short message, full message with trailing pad block, empty message
    msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_msg();
    msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_msg();
    msg.delete();
    run_msg();

    // Back-pressure: held block must stay put and bytes must be refused
    stall = 1'b1;
    msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    begin_msg(ovf);
    n = 0;
    while (!block_valid && n < 50) begin
      tick();
      n++;
    end
    check("stall_valid_seen", 64'(block_valid), 64'd1);
    snap_blk  = block;
    snap_last = block_last;
    byte_valid = 1'b1;
    data_byte  = 8'hEE;
    repeat (5) begin
      tick();
      check("stall_block", block, snap_blk);
      check("stall_last", 64'(block_last), 64'(snap_last));
      check("stall_valid", 64'(block_valid), 64'd1);
      check("stall_byte_ready", 64'(byte_ready), 64'd0);
    end
    byte_valid = 1'b0;
    stall = 1'b0;
    end_msg(ovf);

    // 32 bytes: four blocks fit, the pad block overflows
    msg.delete();
    for (int i = 0; i < 32; i++) msg.push_back(8'(i + 1));
    run_msg();
    repeat (3) tick();
    check("overflow_sticky", 64'(overflow), 64'd1);
    check("overflow_byte_ready", 64'(byte_ready), 64'd0);
    pulse_start();
    check("overflow_cleared", 64'(overflow), 64'd0);

    // Abort a partial message with a fresh start
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    check("abort_no_block", 64'(block_valid), 64'd0);
    msg = '{8'hAA, 8'hBB};
    run_msg();

    // Random messages spanning empty through overflow lengths
    for (int t = 0; t < 24; t++) begin
      msg.delete();
      n = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      run_msg();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
